// File: rtl/instruction_fetch_phase.sv
// IF stage: program counter, imem address, and the IF/ID pipeline register.
// Applies decode-stage redirects with a one-bubble flush and honours stalls.
module instruction_fetch_phase #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpRegister,
  input  logic [31:0] JumpRegTarget,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        misalign_err,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        redirect;
  logic        misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Decode data is stale while the PC is held, so redirects wait too.
  assign redirect = (Branch | Jump | JumpRegister) & PCWrite;

  always_comb begin
    raw_target = pc_plus4;
    priority case (1'b1)
      JumpRegister: raw_target = JumpRegTarget;
      Jump:         raw_target = JumpTarget;
      Branch:       raw_target = BranchTarget;
      default:      raw_target = pc_plus4;
    endcase
  end

  assign target     = {raw_target[31:2], 2'b00};
  assign misaligned = redirect & (|raw_target[1:0]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc           <= RESET_PC;
      instr_out    <= NOP_INSTR;
      pc_out       <= 32'd0;
      valid_out    <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (PCWrite)
        pc <= redirect ? target : pc_plus4;
      if (misaligned)
        misalign_err <= 1'b1;
      if (redirect) begin
        instr_out <= NOP_INSTR;
        pc_out    <= 32'd0;
        valid_out <= 1'b0;
        if (flush_count != 16'hFFFF)
          flush_count <= flush_count + 16'd1;
      end else if (IF_IDWrite) begin
        instr_out   <= imem_data;
        pc_out      <= pc_plus4;
        valid_out   <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Directed bench for instruction_fetch_phase: vector table plus a
// flush-counter saturation sequence. Memory returns word = address.
module tb_instruction_fetch_phase;

  logic        Clk;
  logic        Reset;
  logic        PCWrite;
  logic        IF_IDWrite;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        JumpRegister;
  logic [31:0] JumpRegTarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [15:0] flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  assign imem_data = imem_addr;

  instruction_fetch_phase dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCWrite      (PCWrite),
    .IF_IDWrite   (IF_IDWrite),
    .Branch       (Branch),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .JumpRegister (JumpRegister),
    .JumpRegTarget(JumpRegTarget),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        rst, pcw, ifw, br, j, jr;
    logic [31:0] bt, jt, jrt;
    logic [31:0] e_pc, e_instr, e_pco;
    logic        e_v, e_mis;
    logic [31:0] e_fc;
    logic [15:0] e_flc;
  } vec_t;

  function automatic vec_t mk(
    logic rst, logic pcw, logic ifw,
    logic br, logic [31:0] bt,
    logic j, logic [31:0] jt,
    logic jr, logic [31:0] jrt,
    logic [31:0] e_pc, logic [31:0] e_instr,
    logic [31:0] e_pco, logic e_v, logic e_mis,
    logic [31:0] e_fc, logic [15:0] e_flc);
    vec_t v;
    v.rst = rst; v.pcw = pcw; v.ifw = ifw;
    v.br = br; v.bt = bt;
    v.j = j; v.jt = jt;
    v.jr = jr; v.jrt = jrt;
    v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_pco = e_pco; v.e_v = e_v;
    v.e_mis = e_mis; v.e_fc = e_fc;
    v.e_flc = e_flc;
    return v;
  endfunction

  task automatic chk(input string name, input int step,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h",
               name, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Reset         = v.rst;
    PCWrite       = v.pcw;
    IF_IDWrite    = v.ifw;
    Branch        = v.br;
    BranchTarget  = v.bt;
    Jump          = v.j;
    JumpTarget    = v.jt;
    JumpRegister  = v.jr;
    JumpRegTarget = v.jrt;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0,1,1, 0,0, 0,0, 0,0, 0,0,0,0,0,0,0);
    drive(mk(1,1,1, 0,0, 0,0, 0,0, 0,0,0,0,0,0,0));

    //        rst pcw ifw br bt      j jt            jr jrt
    //        pc            instr         pc_out      v mis fc flc
    tbl.push_back(mk(1,1,1, 0,0, 0,0, 0,0,
      32'h0, 32'h0, 32'h0, 0,0, 0, 0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h4, 32'h0, 32'h4, 1,0, 1, 0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h8, 32'h4, 32'h8, 1,0, 2, 0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'hC, 32'h8, 32'hC, 1,0, 3, 0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h10, 32'hC, 32'h10, 1,0, 4, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,
        32'h10, 32'hC, 32'h10, 1,0, 4, 0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h14, 32'h10, 32'h14, 1,0, 5, 0));
    tbl.push_back(mk(0,1,1, 1,32'h40, 1,32'h80, 0,0,
      32'h80, 32'h0, 32'h0, 0,0, 5, 1));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h84, 32'h80, 32'h84, 1,0, 6, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,32'h103,
      32'h84, 32'h80, 32'h84, 1,0, 6, 1));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 1,32'h103,
      32'h100, 32'h0, 32'h0, 0,1, 6, 2));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h104, 32'h100, 32'h104, 1,1, 7, 2));
    tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,
      32'h108, 32'h100, 32'h104, 1,1, 7, 2));
    tbl.push_back(mk(0,0,1, 0,0, 0,0, 0,0,
      32'h108, 32'h108, 32'h10C, 1,1, 8, 2));
    tbl.push_back(mk(0,1,0, 1,32'h200, 0,0, 0,0,
      32'h200, 32'h0, 32'h0, 0,1, 8, 3));
    tbl.push_back(mk(0,1,1, 1,32'h500, 1,32'h400, 1,32'h300,
      32'h300, 32'h0, 32'h0, 0,1, 8, 4));
    tbl.push_back(mk(0,1,1, 1,32'h500, 1,32'h400, 0,0,
      32'h400, 32'h0, 32'h0, 0,1, 8, 5));
    tbl.push_back(mk(0,1,1, 0,0, 1,32'hFFFF_FFFC, 0,0,
      32'hFFFF_FFFC, 32'h0, 32'h0, 0,1, 8, 6));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h0, 32'hFFFF_FFFC, 32'h0, 1,1, 9, 6));
    tbl.push_back(mk(1,1,1, 1,32'h40, 0,0, 0,0,
      32'h0, 32'h0, 32'h0, 0,0, 0, 0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,0,
      32'h4, 32'h0, 32'h4, 1,0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge Clk);
      #1;
      chk("imem_addr", i, imem_addr, tbl[i].e_pc);
      chk("instr_out", i, instr_out, tbl[i].e_instr);
      chk("pc_out", i, pc_out, tbl[i].e_pco);
      chk("valid_out", i, {31'd0, valid_out}, {31'd0, tbl[i].e_v});
      chk("misalign_err", i, {31'd0, misalign_err},
          {31'd0, tbl[i].e_mis});
      chk("fetch_count", i, fetch_count, tbl[i].e_fc);
      chk("flush_count", i, {16'd0, flush_count},
          {16'd0, tbl[i].e_flc});
    end

    // Saturation: 65535 flushes reach the ceiling, one more must stick.
    drive(mk(1,1,1, 0,0, 0,0, 0,0, 0,0,0,0,0,0,0));
    @(posedge Clk);
    #1;
    chk("sat_reset_flc", 100, {16'd0, flush_count}, 32'h0);
    drive(idle);
    Branch = 1'b1;
    BranchTarget = 32'h0;
    repeat (65534) @(posedge Clk);
    #1;
    chk("sat_pre_flc", 101, {16'd0, flush_count}, 32'hFFFE);
    @(posedge Clk);
    #1;
    chk("sat_flc", 102, {16'd0, flush_count}, 32'hFFFF);
    @(posedge Clk);
    #1;
    chk("sat_hold_flc", 103, {16'd0, flush_count}, 32'hFFFF);
    chk("sat_valid", 103, {31'd0, valid_out}, 32'h0);
    chk("sat_fc", 103, fetch_count, 32'h0);
    chk("sat_pc", 103, imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
